alu_decode: RTL and testbench
=============================

Name: alu_decode

Overview:
- Decode stage that feeds the ALU. Takes a 32-bit RV32I instruction word and produces the ALU's 5-bit alu_op, alu_src, sign-extended immediate, and register indices.
- Sits between instruction fetch and register-file read/ALU.
- Registered, with valid/ready handshakes on both sides and a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction.

Parameters:
- XLEN, 32, datapath/immediate width.
- SKID_DEPTH, 2, output buffering entries; only the value 2 is supported.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  instr is valid this cycle
- in_ready  output  1  stage can accept instr
- instr  input  32  RV32I instruction word
- out_valid  output  1  decoded bundle valid
- out_ready  input  1  consumer accepts bundle
- alu_op  output  5  ALU operation code
- alu_src  output  1  1 = operand B is imm, 0 = rdata2
- imm  output  XLEN  sign-extended I/S immediate
- rs1  output  5  source register 1
- rs2  output  5  source register 2
- rd  output  5  destination register
- illegal  output  1  instruction unsupported by ALU path
- illegal_seen  output  1  sticky illegal flag
- clr_illegal  input  1  synchronous clear of illegal_seen

Behaviour:
- Reset (async assert, sync release):
  - Buffer empty: out_valid=0, in_ready=1.
  - All bundle outputs 0; illegal=0, illegal_seen=0.
- Transfers:
  - Input transfer when in_valid&in_ready. Output transfer when out_valid&out_ready.
  - Latency: instr accepted in cycle N appears on outputs in cycle N+1 if the buffer was empty.
- alu_op encoding (shared with ALU): ADD=00000, SUB=00001, SLL=00010, XOR=00101, SRL=00110, SRA=00111, OR=01000, AND=01001.
- Decode, R-type (opcode 0110011), alu_src=0:
  - f3 000: f7 0000000 -> ADD; 0100000 -> SUB.
  - f3 001: f7 0000000 -> SLL.
  - f3 100 -> XOR; f3 110 -> OR; f3 111 -> AND. f7 must be 0000000.
  - f3 101: f7 0000000 -> SRL; 0100000 -> SRA.
  - Any other f3/f7 combination is illegal.
- Decode, I-type ALU (opcode 0010011), alu_src=1, imm=sext(instr[31:20]):
  - f3 000 -> ADD (never SUB).
  - f3 001 -> SLL, requires instr[31:25]=0000000.
  - f3 101 -> SRL (instr[31:25]=0000000) or SRA (0100000); imm carries shamt in imm[4:0].
  - f3 100/110/111 -> XOR/OR/AND.
- Decode, load (0000011): ADD, alu_src=1, imm=sext(instr[31:20]).
- Decode, store (0100011): ADD, alu_src=1, imm=sext({instr[31:25],instr[11:7]}).
- f3 010/011 (SLT/SLTU): illegal, because the ALU has no compare op.
- Illegal instructions and unknown opcodes:
  - Still flow through the pipeline with illegal=1, alu_op=ADD, alu_src=0, imm=0.
  - Register fields are always passed raw: rs1=instr[19:15], rs2=instr[24:20], rd=instr[11:7].
- illegal_seen:
  - Set on the output transfer of an illegal bundle.
  - Cleared by clr_illegal. If clear and set occur in the same cycle, set wins.
- Skid buffer, states EMPTY / ONE / FULL:
  - EMPTY: in accept -> ONE.
  - ONE: accept without drain -> FULL; drain without accept -> EMPTY; accept and drain together -> ONE.
  - FULL: drain -> ONE.
- in_ready is registered: 1 in EMPTY/ONE, 0 in FULL. Never combinationally dependent on out_ready.
- Ordering: strictly FIFO.
- Output stability: outputs hold stable while out_valid&!out_ready.
- Reset mid-operation: both entries are discarded and out_valid drops immediately.

Optional Feature:
- Macro: ALU_DEC_STATS_EN.
- When defined, adds three output ports, each reset to 0:
  - dec_count (32): output transfers.
  - illegal_count (16): illegal output transfers; saturates at 16'hFFFF.
  - stall_cycles (32): cycles with out_valid&!out_ready.
- dec_count and stall_cycles wrap around.
- clr_illegal also clears illegal_count.
- When not defined: no ports, no counter logic.

Decomposition:
- Package alu_pkg:
  - alu_op_e enum (5-bit, values above).
  - Opcode constants OPC_RTYPE, OPC_ITYPE, OPC_LOAD, OPC_STORE.
  - F7_BASE=7'b0000000, F7_ALT=7'b0100000.
  - Packed struct dec_bundle_t {alu_op, alu_src, imm, rs1, rs2, rd, illegal}.
- The ALU imports the same alu_pkg.
- Sub-module alu_dec_skid: generic 2-entry valid/ready skid buffer carrying dec_bundle_t.
- Decode logic itself is a combinational function in the top module.

Test Plan:
- add x3,x1,x2 (32'h002081B3), out_ready=1 -> next cycle alu_op=00000, alu_src=0, rs1=1, rs2=2, rd=3, illegal=0.
- Reserved-bit and immediate/shift checks, out_ready=1:
  - 32'h4020D1B3 (sra) -> alu_op=00111.
  - 32'hFFF08193 (addi x3,x1,-1) -> alu_op=00000, alu_src=1, imm=32'hFFFFFFFF.
  - 32'h4030D193 (srai x3,x1,3) -> alu_op=00111, imm[4:0]=3.
- sw x2,-4(x1) (32'hFE20AE23) -> alu_op=00000, alu_src=1, imm=32'hFFFFFFFC.
- slt (32'h0020A1B3) -> illegal=1, alu_op=00000.
  - After the transfer illegal_seen=1.
  - clr_illegal alone clears it; clr_illegal in the same cycle as another illegal transfer leaves it 1.
- Back-pressure:
  - Hold out_ready=0, stream 3 instrs -> in_ready drops after the 2nd accept; outputs stay stable.
  - Then release out_ready -> all three emerge in order with no loss or duplication.
- Assert rst_n=0 with the buffer FULL -> out_valid=0 and in_ready=1 immediately; no stale bundle after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU/decode types: operation codes, RV32I opcode constants and the decoded bundle.
package alu_pkg;

    localparam int DEC_XLEN = 32;

    typedef enum logic [4:0] {
        ALU_ADD = 5'b00000,
        ALU_SUB = 5'b00001,
        ALU_SLL = 5'b00010,
        ALU_XOR = 5'b00101,
        ALU_SRL = 5'b00110,
        ALU_SRA = 5'b00111,
        ALU_OR  = 5'b01000,
        ALU_AND = 5'b01001
    } alu_op_e;

    localparam logic [6:0] OPC_RTYPE = 7'b0110011;
    localparam logic [6:0] OPC_ITYPE = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_e;

    typedef struct packed {
        alu_op_e               alu_op;
        logic                  alu_src;
        logic [DEC_XLEN-1:0]   imm;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [4:0]            rd;
        logic                  illegal;
    } dec_bundle_t;

endpackage

// File: rtl/alu_decode_if.sv
// Fetch-side and ALU-side handshake bundle of the decode stage.
interface alu_decode_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instr;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      alu_op;
    logic            alu_src;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            illegal;

    // slave is the decode stage itself, master is whoever drives fetch and consumes the bundle
    modport slave (
        input  in_valid, instr, out_ready,
        output in_ready, out_valid, alu_op, alu_src, imm, rs1, rs2, rd, illegal
    );

    modport master (
        output in_valid, instr, out_ready,
        input  in_ready, out_valid, alu_op, alu_src, imm, rs1, rs2, rd, illegal
    );
endinterface

// File: rtl/alu_dec_skid.sv
// Two-entry valid/ready skid buffer; in_ready is registered so it never depends on out_ready.
module alu_dec_skid
    import alu_pkg::*;
#(
    parameter type T     = dec_bundle_t,
    parameter int  DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  T     in_data,
    output logic out_valid,
    input  logic out_ready,
    output T     out_data
);

    skid_state_e state_q, state_d;
    logic        in_ready_q;
    logic        in_fire, out_fire;
    logic        ld_head, ld_tail, head_from_tail;
    T            mem [DEPTH];

    assign in_ready = in_ready_q;
    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SKID_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != SKID_FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SKID_EMPTY: if (in_fire) state_d = SKID_ONE;
            SKID_ONE: begin
                if (in_fire && !out_fire)      state_d = SKID_FULL;
                else if (!in_fire && out_fire) state_d = SKID_EMPTY;
            end
            SKID_FULL:  if (out_fire) state_d = SKID_ONE;
            default:    state_d = SKID_EMPTY;
        endcase
    end

    // mem[0] is always the head presented on the output
    always_comb begin
        out_valid      = (state_q != SKID_EMPTY);
        out_data       = mem[0];
        ld_head        = 1'b0;
        ld_tail        = 1'b0;
        head_from_tail = 1'b0;
        case (state_q)
            SKID_EMPTY: ld_head = in_fire;
            SKID_ONE: begin
                ld_head = in_fire & out_fire;
                ld_tail = in_fire & ~out_fire;
            end
            SKID_FULL: begin
                ld_head        = out_fire;
                head_from_tail = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (ld_head) mem[0] <= head_from_tail ? mem[1] : in_data;
            if (ld_tail) mem[1] <= in_data;
        end
    end

endmodule

// File: rtl/alu_decode.sv
// RV32I decode stage feeding the ALU, registered through a 2-entry skid buffer.
// Define ALU_DEC_STATS_EN to add dec_count / illegal_count / stall_cycles counters.
module alu_decode
    import alu_pkg::*;
#(
    parameter int XLEN       = DEC_XLEN,
    parameter int SKID_DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_decode_if.slave   bus,
    input  logic          clr_illegal,
    output logic          illegal_seen
`ifdef ALU_DEC_STATS_EN
    ,
    output logic [31:0]   dec_count,
    output logic [15:0]   illegal_count,
    output logic [31:0]   stall_cycles
`endif
);

    function automatic dec_bundle_t decode(input logic [31:0] ins);
        dec_bundle_t d;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic        bad;
        f7        = ins[31:25];
        f3        = ins[14:12];
        bad       = 1'b0;
        d         = '0;
        d.alu_op  = ALU_ADD;
        d.rs1     = ins[19:15];
        d.rs2     = ins[24:20];
        d.rd      = ins[11:7];
        case (ins[6:0])
            OPC_RTYPE: begin
                case (f3)
                    3'b000: begin
                        if (f7 == F7_BASE)     d.alu_op = ALU_ADD;
                        else if (f7 == F7_ALT) d.alu_op = ALU_SUB;
                        else                   bad = 1'b1;
                    end
                    3'b001: begin
                        d.alu_op = ALU_SLL;
                        bad      = (f7 != F7_BASE);
                    end
                    3'b100: begin
                        d.alu_op = ALU_XOR;
                        bad      = (f7 != F7_BASE);
                    end
                    3'b101: begin
                        if (f7 == F7_BASE)     d.alu_op = ALU_SRL;
                        else if (f7 == F7_ALT) d.alu_op = ALU_SRA;
                        else                   bad = 1'b1;
                    end
                    3'b110: begin
                        d.alu_op = ALU_OR;
                        bad      = (f7 != F7_BASE);
                    end
                    3'b111: begin
                        d.alu_op = ALU_AND;
                        bad      = (f7 != F7_BASE);
                    end
                    default: bad = 1'b1;
                endcase
            end
            OPC_ITYPE: begin
                d.alu_src = 1'b1;
                d.imm     = {{(XLEN-12){ins[31]}}, ins[31:20]};
                case (f3)
                    3'b000: d.alu_op = ALU_ADD;
                    3'b001: begin
                        d.alu_op = ALU_SLL;
                        bad      = (f7 != F7_BASE);
                    end
                    3'b100: d.alu_op = ALU_XOR;
                    3'b101: begin
                        if (f7 == F7_BASE)     d.alu_op = ALU_SRL;
                        else if (f7 == F7_ALT) d.alu_op = ALU_SRA;
                        else                   bad = 1'b1;
                    end
                    3'b110: d.alu_op = ALU_OR;
                    3'b111: d.alu_op = ALU_AND;
                    default: bad = 1'b1;
                endcase
            end
            OPC_LOAD: begin
                d.alu_src = 1'b1;
                d.imm     = {{(XLEN-12){ins[31]}}, ins[31:20]};
            end
            OPC_STORE: begin
                d.alu_src = 1'b1;
                d.imm     = {{(XLEN-12){ins[31]}}, ins[31:25], ins[11:7]};
            end
            default: bad = 1'b1;
        endcase
        // illegal bundles still flow, but carry a neutral ALU setup
        if (bad) begin
            d.alu_op  = ALU_ADD;
            d.alu_src = 1'b0;
            d.imm     = '0;
        end
        d.illegal = bad;
        return d;
    endfunction

    dec_bundle_t dec_in, dec_out;
    logic        out_valid;
    logic        out_fire;

    assign dec_in = decode(bus.instr);

    alu_dec_skid #(
        .T     (dec_bundle_t),
        .DEPTH (SKID_DEPTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (dec_in),
        .out_valid (out_valid),
        .out_ready (bus.out_ready),
        .out_data  (dec_out)
    );

    assign out_fire      = out_valid & bus.out_ready;
    assign bus.out_valid = out_valid;
    assign bus.alu_op    = dec_out.alu_op;
    assign bus.alu_src   = dec_out.alu_src;
    assign bus.imm       = dec_out.imm;
    assign bus.rs1       = dec_out.rs1;
    assign bus.rs2       = dec_out.rs2;
    assign bus.rd        = dec_out.rd;
    assign bus.illegal   = dec_out.illegal;

    // a new illegal transfer beats a concurrent clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          illegal_seen <= 1'b0;
        else if (out_fire && dec_out.illegal) illegal_seen <= 1'b1;
        else if (clr_illegal)                illegal_seen <= 1'b0;
    end

`ifdef ALU_DEC_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_count     <= '0;
            illegal_count <= '0;
            stall_cycles  <= '0;
        end else begin
            if (out_fire)                   dec_count    <= dec_count + 32'd1;
            if (out_valid && !bus.out_ready) stall_cycles <= stall_cycles + 32'd1;
            if (clr_illegal)
                illegal_count <= (out_fire && dec_out.illegal) ? 16'd1 : 16'd0;
            else if (out_fire && dec_out.illegal && illegal_count != 16'hFFFF)
                illegal_count <= illegal_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_decode.sv
// Bench for alu_decode: directed decode vectors, sticky flag, back-pressure, random scoreboard, reset.
module tb_alu_decode;

    typedef struct packed {
        logic [4:0]  op;
        logic        src;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic clr_illegal;
    logic illegal_seen;
    int   n_vec = 0;
    int   n_err = 0;

    // f3 -> op for the base (f7 = 0) R-type group; -1 marks no ALU op
    int r_base [8] = '{0, 2, -1, -1, 5, 6, 8, 9};

    alu_decode_if #(.XLEN(32)) bus ();

`ifdef ALU_DEC_STATS_EN
    logic [31:0] dec_count;
    logic [15:0] illegal_count;
    logic [31:0] stall_cycles;
`endif

    alu_decode #(.XLEN(32), .SKID_DEPTH(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .clr_illegal  (clr_illegal),
        .illegal_seen (illegal_seen)
`ifdef ALU_DEC_STATS_EN
        ,
        .dec_count     (dec_count),
        .illegal_count (illegal_count),
        .stall_cycles  (stall_cycles)
`endif
    );

    initial forever #5 clk = ~clk;

    function automatic exp_t ref_dec(input logic [31:0] w);
        exp_t        e;
        int          op;
        logic        src;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        f3  = w[14:12];
        f7  = w[31:25];
        e   = '0;
        e.rs1 = w[19:15];
        e.rs2 = w[24:20];
        e.rd  = w[11:7];
        op  = -1;
        src = 1'b0;
        imm = 32'h0;
        case (w[6:0])
            7'h33: begin
                if (f7 == 7'h00)      op = r_base[f3];
                else if (f7 == 7'h20) op = (f3 == 3'd0) ? 1 : (f3 == 3'd5) ? 7 : -1;
            end
            7'h13: begin
                src = 1'b1;
                imm = {{20{w[31]}}, w[31:20]};
                if (f3 == 3'd1)      op = (f7 == 7'h00) ? 2 : -1;
                else if (f3 == 3'd5) op = (f7 == 7'h00) ? 6 : (f7 == 7'h20) ? 7 : -1;
                else                 op = r_base[f3];
            end
            7'h03: begin
                op = 0; src = 1'b1; imm = {{20{w[31]}}, w[31:20]};
            end
            7'h23: begin
                op = 0; src = 1'b1; imm = {{20{w[31]}}, w[31:25], w[11:7]};
            end
            default: op = -1;
        endcase
        if (op < 0) begin
            e.ill = 1'b1;
        end else begin
            e.op  = op[4:0];
            e.src = src;
            e.imm = imm;
        end
        return e;
    endfunction

    function automatic exp_t act();
        exp_t a;
        a.op  = bus.alu_op;
        a.src = bus.alu_src;
        a.imm = bus.imm;
        a.rs1 = bus.rs1;
        a.rs2 = bus.rs2;
        a.rd  = bus.rd;
        a.ill = bus.illegal;
        return a;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 5))
            0, 5: w[6:0] = 7'h33;
            1:    w[6:0] = 7'h13;
            2:    w[6:0] = 7'h03;
            3:    w[6:0] = 7'h23;
            default: ;
        endcase
        case ($urandom_range(0, 2))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || illegal_seen !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hs: out_valid=%b in_ready=%b seen=%b want 0 1 0", bus.out_valid, bus.in_ready, illegal_seen);
        end
        n_vec++;
        if (act() !== exp_t'(0)) begin
            n_err++;
            $display("FAIL reset_bundle: got %h want 0", act());
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] d_in [6];
        exp_t        d_exp [6];
        d_in[0] = 32'h002081B3; d_exp[0] = '{op:5'd0, src:1'b0, imm:32'h0,        rs1:5'd1, rs2:5'd2,  rd:5'd3,  ill:1'b0};
        d_in[1] = 32'h4020D1B3; d_exp[1] = '{op:5'd7, src:1'b0, imm:32'h0,        rs1:5'd1, rs2:5'd2,  rd:5'd3,  ill:1'b0};
        d_in[2] = 32'hFFF08193; d_exp[2] = '{op:5'd0, src:1'b1, imm:32'hFFFFFFFF, rs1:5'd1, rs2:5'd31, rd:5'd3,  ill:1'b0};
        d_in[3] = 32'h4030D193; d_exp[3] = '{op:5'd7, src:1'b1, imm:32'h00000403, rs1:5'd1, rs2:5'd3,  rd:5'd3,  ill:1'b0};
        d_in[4] = 32'hFE20AE23; d_exp[4] = '{op:5'd0, src:1'b1, imm:32'hFFFFFFFC, rs1:5'd1, rs2:5'd2,  rd:5'd28, ill:1'b0};
        d_in[5] = 32'h0020A1B3; d_exp[5] = '{op:5'd0, src:1'b0, imm:32'h0,        rs1:5'd1, rs2:5'd2,  rd:5'd3,  ill:1'b1};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.instr    = d_in[i];
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            n_vec++;
            if (bus.out_valid !== 1'b1 || act() !== d_exp[i]) begin
                n_err++;
                $display("FAIL directed_%0d (%h): valid=%b got %h want %h", i, d_in[i], bus.out_valid, act(), d_exp[i]);
            end
            @(posedge clk); #1;
            n_vec++;
            if (bus.out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL directed_drain_%0d: out_valid=%b want 0", i, bus.out_valid);
            end
        end
    endtask

    task automatic test_illegal();
        bus.out_ready = 1'b1;
        clr_illegal   = 1'b1;
        @(posedge clk); #1;
        clr_illegal = 1'b0;
        n_vec++;
        if (illegal_seen !== 1'b0) begin
            n_err++;
            $display("FAIL sticky_clear: seen=%b want 0", illegal_seen);
        end
        // slt reaches the output, then clears in the same cycle it transfers
        bus.in_valid = 1'b1;
        bus.instr    = 32'h0020A1B3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        clr_illegal  = 1'b1;
        @(posedge clk); #1;
        clr_illegal = 1'b0;
        n_vec++;
        if (illegal_seen !== 1'b1) begin
            n_err++;
            $display("FAIL sticky_set_wins: seen=%b want 1", illegal_seen);
        end
        clr_illegal = 1'b1;
        @(posedge clk); #1;
        clr_illegal = 1'b0;
        n_vec++;
        if (illegal_seen !== 1'b0) begin
            n_err++;
            $display("FAIL sticky_clear2: seen=%b want 0", illegal_seen);
        end
        bus.in_valid = 1'b1;
        bus.instr    = 32'h002081B3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (illegal_seen !== 1'b0) begin
            n_err++;
            $display("FAIL sticky_legal: seen=%b want 0", illegal_seen);
        end
    endtask

    task automatic test_back_pressure();
        logic [31:0] seq [3];
        int          got;
        logic        sent_c;
        seq[0] = 32'h002081B3;
        seq[1] = 32'hFFF08193;
        seq[2] = 32'h4030D193;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = seq[0];
        @(posedge clk); #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL bp_ready_one: in_ready=%b want 1", bus.in_ready);
        end
        bus.instr = seq[1];
        @(posedge clk); #1;
        bus.instr = seq[2];
        for (int c = 0; c < 3; c++) begin
            n_vec++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || act() !== ref_dec(seq[0])) begin
                n_err++;
                $display("FAIL bp_hold_%0d: in_ready=%b valid=%b got %h want %h", c, bus.in_ready, bus.out_valid, act(), ref_dec(seq[0]));
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (bus.out_valid) begin
                n_vec++;
                if (act() !== ref_dec(seq[got])) begin
                    n_err++;
                    $display("FAIL bp_order_%0d: got %h want %h", got, act(), ref_dec(seq[got]));
                end
                got++;
            end
            sent_c = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            if (sent_c) bus.in_valid = 1'b0;
        end
        n_vec++;
        if (got != 3 || bus.out_valid !== 1'b0 || bus.in_valid !== 1'b0) begin
            n_err++;
            $display("FAIL bp_count: got %0d bundles valid=%b want 3 and 0", got, bus.out_valid);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_random();
        exp_t q [$];
        logic seen_m;
        logic fire_ill;
        clr_illegal = 1'b1;
        @(posedge clk); #1;
        clr_illegal = 1'b0;
        seen_m      = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus.in_valid  = ($urandom_range(0, 99) < 60);
            bus.instr     = rand_instr();
            bus.out_ready = ($urandom_range(0, 99) < 55);
            clr_illegal   = ($urandom_range(0, 99) < 8);
            fire_ill      = 1'b0;
            n_vec++;
            if (bus.in_ready !== (q.size() < 2) || bus.out_valid !== (q.size() != 0)) begin
                n_err++;
                $display("FAIL rnd_occ_%0d: in_ready=%b out_valid=%b model depth %0d", c, bus.in_ready, bus.out_valid, q.size());
            end
            if (bus.out_valid && bus.out_ready && q.size() != 0) begin
                n_vec++;
                if (act() !== q[0]) begin
                    n_err++;
                    $display("FAIL rnd_data_%0d: got %h want %h", c, act(), q[0]);
                end
                fire_ill = q[0].ill;
                void'(q.pop_front());
            end
            if (bus.in_valid && bus.in_ready) q.push_back(ref_dec(bus.instr));
            seen_m = fire_ill ? 1'b1 : clr_illegal ? 1'b0 : seen_m;
            @(posedge clk); #1;
            n_vec++;
            if (illegal_seen !== seen_m) begin
                n_err++;
                $display("FAIL rnd_seen_%0d: seen=%b want %b", c, illegal_seen, seen_m);
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        clr_illegal   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (bus.out_valid && q.size() != 0) begin
                n_vec++;
                if (act() !== q[0]) begin
                    n_err++;
                    $display("FAIL rnd_drain_%0d: got %h want %h", c, act(), q[0]);
                end
                void'(q.pop_front());
            end
            @(posedge clk); #1;
        end
        n_vec++;
        if (q.size() != 0 || bus.out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rnd_empty: model depth %0d out_valid=%b want 0 0", q.size(), bus.out_valid);
        end
    endtask

    task automatic test_reset_midop();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = 32'h002081B3;
        @(posedge clk); #1;
        bus.instr = 32'h0020A1B3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_full: in_ready=%b out_valid=%b want 0 1", bus.in_ready, bus.out_valid);
        end
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || act() !== exp_t'(0)) begin
            n_err++;
            $display("FAIL midrst_async: valid=%b ready=%b bundle %h want 0 1 0", bus.out_valid, bus.in_ready, act());
        end
        @(posedge clk); #1;
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            n_vec++;
            if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL midrst_stale_%0d: valid=%b ready=%b want 0 1", c, bus.out_valid, bus.in_ready);
            end
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.instr     = 32'h0;
        bus.out_ready = 1'b0;
        clr_illegal   = 1'b0;
        rst_n         = 1'b0;
        test_reset();
        test_directed();
        test_illegal();
        test_back_pressure();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
